// File: rtl/p2s_arb_ctrl.sv
// Round-robin arbiter feeding one MSB-first parallel-to-serial shifter.
// One IDLE grant cycle per frame, then WIDTH enabled shift cycles.
module p2s_arb_ctrl #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     ser_en,
   output logic                     ser_dout,
   output logic                     ser_valid,
   output logic                     ser_start,
   output logic                     ser_last,
   output logic [IDW-1:0]           ser_id,
   output logic                     busy
);

   localparam int unsigned CNTW = $clog2(WIDTH);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
   localparam logic [IDW-1:0]  ID_LAST  = IDW'(N_REQ - 1);
   localparam logic [IDW:0]    N_WIDE   = (IDW + 1)'(N_REQ);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     ser_id_q, ser_id_d;
   logic               dout_q, dout_d;
   logic               valid_q, valid_d;
   logic               start_q, start_d;
   logic               last_q, last_d;
   logic               busy_q, busy_d;

   logic [2*N_REQ-1:0] rot_valid;
   logic               grant_vld;
   logic [IDW:0]       grant_sum;
   logic [IDW-1:0]     grant_id;
   logic [N_REQ-1:0]   grant_onehot;
   logic [WIDTH-1:0]   grant_word;
   logic [CNTW-1:0]    cnt_inc;

   // Rotate valids so bit 0 is the requester at ptr, then take the first set bit.
   always_comb begin
      rot_valid = {req_valid, req_valid} >> ptr_q;
      grant_vld = 1'b0;
      grant_sum = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_vld && rot_valid[k]) begin
            grant_vld = 1'b1;
            grant_sum = {1'b0, ptr_q} + (IDW + 1)'(k);
         end
      end
      if (grant_sum >= N_WIDE) begin
         grant_sum = grant_sum - N_WIDE;
      end
      grant_id = grant_sum[IDW-1:0];
   end

   // Decode the winner into a one-hot ready and select its word.
   always_comb begin
      grant_onehot = '0;
      grant_word   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_vld && (grant_id == IDW'(i))) begin
            grant_onehot[i] = 1'b1;
            grant_word      = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Ready is forced low while reset is held so nothing is accepted into a dead frame.
   always_comb begin
      req_ready = '0;
      if (rst_n && (state_q == ST_IDLE)) begin
         req_ready = grant_onehot;
      end
   end

   assign cnt_inc = cnt_q + CNTW'(1);

   // Next-state and registered output values.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      ser_id_d = ser_id_q;
      dout_d   = dout_q;
      valid_d  = valid_q;
      start_d  = start_q;
      last_d   = last_q;
      busy_d   = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               state_d  = ST_SHIFT;
               shreg_d  = grant_word;
               cnt_d    = '0;
               ser_id_d = grant_id;
               ptr_d    = (grant_id == ID_LAST) ? '0 : grant_id + IDW'(1);
               dout_d   = grant_word[WIDTH-1];
               valid_d  = 1'b1;
               start_d  = 1'b1;
               last_d   = 1'b0;
               busy_d   = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (ser_en) begin
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               cnt_d   = cnt_inc;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
                  dout_d  = 1'b0;
                  valid_d = 1'b0;
                  start_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  dout_d  = shreg_q[WIDTH-2];
                  start_d = 1'b0;
                  last_d  = (cnt_inc == CNT_LAST);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         ptr_q    <= '0;
         ser_id_q <= '0;
         dout_q   <= 1'b0;
         valid_q  <= 1'b0;
         start_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         ser_id_q <= ser_id_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         start_q  <= start_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
      end
   end

   assign ser_dout  = dout_q;
   assign ser_valid = valid_q;
   assign ser_start = start_q;
   assign ser_last  = last_q;
   assign ser_id    = ser_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_p2s_arb_ctrl.sv
// Directed bench for p2s_arb_ctrl: per-cycle vector table plus hand-written
// reset sequences. Inputs change on the falling edge, outputs checked 1ns later.
module tb_p2s_arb_ctrl;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        ser_en;
   logic        ser_dout;
   logic        ser_valid;
   logic        ser_start;
   logic        ser_last;
   logic [1:0]  ser_id;
   logic        busy;

   int n_tests;
   int n_fail;

   // Output bundle: {ready[3:0], valid, dout, start, last, id[1:0], busy}
   typedef struct packed {
      logic [3:0]  valid;
      logic [15:0] data;
      logic        en;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[$];

   p2s_arb_ctrl #(.N_REQ(4), .WIDTH(4), .IDW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .ser_en    (ser_en),
      .ser_dout  (ser_dout),
      .ser_valid (ser_valid),
      .ser_start (ser_start),
      .ser_last  (ser_last),
      .ser_id    (ser_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] pk(input logic [3:0] rdy, input logic sv, input logic dout,
                                      input logic st, input logic last, input logic [1:0] id,
                                      input logic bsy);
      return {rdy, sv, dout, st, last, id, bsy};
   endfunction

   function automatic logic [10:0] outs();
      return {req_ready, ser_valid, ser_dout, ser_start, ser_last, ser_id, busy};
   endfunction

   task automatic add(input logic [3:0] v, input logic [15:0] d, input logic en, input logic [10:0] e);
      vec_t x;
      x.valid = v;
      x.data  = d;
      x.en    = en;
      x.exp   = e;
      vecs.push_back(x);
   endtask

   task automatic t_idle(input logic [3:0] v, input logic [15:0] d, input logic [3:0] rdy,
                         input logic [1:0] id);
      add(v, d, 1'b1, pk(rdy, 1'b0, 1'b0, 1'b0, 1'b0, id, 1'b0));
   endtask

   task automatic t_bit(input logic [3:0] v, input logic [15:0] d, input logic en, input logic dout,
                        input logic st, input logic last, input logic [1:0] id);
      add(v, d, en, pk(4'b0000, 1'b1, dout, st, last, id, 1'b1));
   endtask

   task automatic t_frame(input logic [3:0] v, input logic [15:0] d, input logic [3:0] bits,
                          input logic [1:0] id);
      for (int b = 0; b < 4; b++) begin
         t_bit(v, d, 1'b1, bits[3-b], b == 0, b == 3, id);
      end
   endtask

   task automatic compare(input string name, input logic [10:0] exp);
      logic [10:0] got;
      got = outs();
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got {rdy,vld,dout,st,last,id,busy}=%b expected %b", name, got, exp);
      end
   endtask

   task automatic step(input string name, input logic [3:0] v, input logic [15:0] d,
                       input logic en, input logic [10:0] exp);
      @(negedge clk);
      req_valid = v;
      req_data  = d;
      ser_en    = en;
      #1;
      compare(name, exp);
   endtask

   task automatic build_table();
      logic [15:0] d;
      logic [1:0]  prev;
      // Single frame from requester 1, word 1011
      d = 16'h00B0;
      t_idle(4'b0010, d, 4'b0010, 2'd0);
      t_frame(4'b0000, d, 4'b1011, 2'd1);
      t_idle(4'b0000, d, 4'b0000, 2'd1);
      // Stall of three cycles on bit 2 of requester 2's word 1100
      d = 16'h0C00;
      t_idle(4'b0100, d, 4'b0100, 2'd1);
      t_bit(4'b0000, d, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
      t_bit(4'b0000, d, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
      t_bit(4'b0000, d, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
      t_bit(4'b0000, d, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
      t_bit(4'b0000, d, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
      t_bit(4'b0000, d, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
      t_bit(4'b0000, d, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      // Requester 3, word 0101, stall on the last bit holds ser_last
      d = 16'h5000;
      t_idle(4'b1000, d, 4'b1000, 2'd2);
      t_bit(4'b0000, d, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
      t_bit(4'b0000, d, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
      t_bit(4'b0000, d, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
      t_bit(4'b0000, d, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
      t_bit(4'b0000, d, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
      // Pointer wrapped to 0: requester 0 beats 3, then 3 is served
      d = 16'h500E;
      t_idle(4'b1001, d, 4'b0001, 2'd3);
      t_frame(4'b1000, d, 4'b1110, 2'd0);
      t_idle(4'b1000, d, 4'b1000, 2'd0);
      t_frame(4'b0000, d, 4'b0101, 2'd3);
      // Full contention: grants 0,1,2,3,0,1 with 5-cycle frame period
      d = 16'h1248;
      for (int r = 0; r < 6; r++) begin
         prev = (r == 0) ? 2'd3 : 2'(r - 1);
         t_idle(4'b1111, d, 4'(1 << (r % 4)), prev);
         t_frame(4'b1111, d, 4'(4'b1000 >> (r % 4)), 2'(r % 4));
      end
      t_idle(4'b0000, d, 4'b0000, 2'd1);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req_valid = 4'b0001;
      req_data  = 16'h0009;
      ser_en    = 1'b1;
      build_table();

      // Reset state, then first grant goes to requester 0
      step("rst_hold0", 4'b0001, 16'h0009, 1'b1, pk(4'b0000, 0, 0, 0, 0, 2'd0, 0));
      step("rst_hold1", 4'b0001, 16'h0009, 1'b1, pk(4'b0000, 0, 0, 0, 0, 2'd0, 0));
      #1 rst_n = 1'b1;
      #1 compare("rst_first_grant", pk(4'b0001, 0, 0, 0, 0, 2'd0, 0));
      step("rst_f0", 4'b0000, 16'h0009, 1'b1, pk(4'b0000, 1, 1, 1, 0, 2'd0, 1));
      step("rst_f1", 4'b0000, 16'h0009, 1'b1, pk(4'b0000, 1, 0, 0, 0, 2'd0, 1));
      step("rst_f2", 4'b0000, 16'h0009, 1'b1, pk(4'b0000, 1, 0, 0, 0, 2'd0, 1));
      step("rst_f3", 4'b0000, 16'h0009, 1'b1, pk(4'b0000, 1, 1, 0, 1, 2'd0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].en, vecs[i].exp);
      end

      // Reset during bit 2 of requester 2's frame, requester keeps valid high
      step("rmf_grant", 4'b0100, 16'h0A00, 1'b1, pk(4'b0100, 0, 0, 0, 0, 2'd1, 0));
      step("rmf_bit1",  4'b0100, 16'h0A00, 1'b1, pk(4'b0000, 1, 1, 1, 0, 2'd2, 1));
      step("rmf_bit2",  4'b0100, 16'h0A00, 1'b1, pk(4'b0000, 1, 0, 0, 0, 2'd2, 1));
      #1 rst_n = 1'b0;
      #1 compare("rmf_async", pk(4'b0000, 0, 0, 0, 0, 2'd0, 0));
      step("rmf_hold",  4'b0100, 16'h0A00, 1'b1, pk(4'b0000, 0, 0, 0, 0, 2'd0, 0));
      #1 rst_n = 1'b1;
      #1 compare("rmf_regrant", pk(4'b0100, 0, 0, 0, 0, 2'd0, 0));
      step("rmf_f0", 4'b0000, 16'h0A00, 1'b1, pk(4'b0000, 1, 1, 1, 0, 2'd2, 1));
      step("rmf_f1", 4'b0000, 16'h0A00, 1'b1, pk(4'b0000, 1, 0, 0, 0, 2'd2, 1));
      step("rmf_f2", 4'b0000, 16'h0A00, 1'b1, pk(4'b0000, 1, 1, 0, 0, 2'd2, 1));
      step("rmf_f3", 4'b0000, 16'h0A00, 1'b1, pk(4'b0000, 1, 0, 0, 1, 2'd2, 1));
      step("rmf_end", 4'b0000, 16'h0A00, 1'b1, pk(4'b0000, 0, 0, 0, 0, 2'd2, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/p2s_arb_ctrl.md
# p2s_arb_ctrl

Round-robin controller that shares one MSB-first parallel-to-serial shifter among several requesters. Each requester presents a parallel word with a valid/ready handshake. The controller grants one requester, loads its word into the internal shifter, and sequences the bits onto a single serial line with framing strobes and the source ID. It sits between the parallel producers and the serial link, and owns all arbitration and frame sequencing for that link.

## Interface
- N_REQ, 4, number of requesters (2..16; need not be a power of 2)
- WIDTH, 4, bits per word (>= 2)
- IDW, 2, width of the requester ID; must equal ceil(log2(N_REQ))
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester word-valid
- req_data  in  N_REQ*WIDTH  requester i's word is at bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  accept strobe, at most one bit high
- ser_en  in  1  shift enable; low stalls the frame
- ser_dout  out  1  serial data, MSB first
- ser_valid  out  1  high while a frame bit is on ser_dout
- ser_start  out  1  high on the first bit of a frame
- ser_last  out  1  high on the last bit of a frame
- ser_id  out  IDW  index of the requester that owns the current frame
- busy  out  1  high whenever state is SHIFT

## Operation
- State machine has two states: IDLE and SHIFT.
- Internal registers:
  - shreg: WIDTH bits.
  - cnt: ceil(log2(WIDTH)) bits.
  - ptr: IDW bits, the round-robin start point.
  - ser_id_r: IDW bits.
- IDLE:
  - Winner is the first i with req_valid[i]=1, searching ptr, ptr+1, … N_REQ-1, 0, … ptr-1.
  - req_ready[winner] is driven combinationally high in the same cycle. All other ready bits stay 0.
  - At the clock edge:
    - shreg <= winner's word.
    - ser_id_r <= winner.
    - cnt <= 0.
    - ptr <= winner+1, wrapping N_REQ-1 to 0.
    - state -> SHIFT.
  - If no req_valid bit is set: state stays IDLE and no register changes.
- SHIFT:
  - Outputs:
    - ser_valid=1.
    - ser_dout=shreg[WIDTH-1].
    - ser_start=(cnt==0).
    - ser_last=(cnt==WIDTH-1).
    - req_ready is all 0.
  - If ser_en=1 at the edge:
    - shreg <= shreg<<1, zero-filled.
    - cnt <= cnt+1.
    - If cnt==WIDTH-1: state -> IDLE.
  - If ser_en=0: all state holds, and every output holds its value.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high. A requester keeps its valid and data stable until that happens. A requester may drop valid before ready; it then simply loses arbitration.
- ser_en is ignored in IDLE. Loading a word never stalls.
- Outside SHIFT: ser_valid, ser_start, ser_last and ser_dout are 0, and ser_id holds the last granted ID.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE.
  - shreg, cnt, ptr, ser_id all 0.
  - Outputs: ser_dout=0, ser_valid=0, ser_start=0, ser_last=0, busy=0, req_ready=0.
- Latency:
  - req_ready rises in the IDLE cycle where the winner is decided.
  - The first bit appears on the next cycle.
  - With ser_en held high, a frame lasts WIDTH cycles.
- Minimum frame period is WIDTH+1 cycles: one IDLE grant cycle between back-to-back frames.
- Each low cycle of ser_en during SHIFT extends the frame by exactly one cycle.
- Simultaneous requests: strict round-robin. A continuously requesting requester waits at most N_REQ-1 frames.
- ptr wrap: after a grant to N_REQ-1, ptr=0.
- Reset mid-frame: the frame is aborted and the accepted word is lost; there is no resume. After release, arbitration restarts from ptr=0.
- ser_en=0 on the last bit: state stays in SHIFT and ser_last stays high until an enabled edge.

## Test plan
- Reset check: assert rst_n low mid-operation, then release. Required: all outputs 0, first grant goes to requester 0 if it is requesting.
- Single frame: requester 1 only, data 4'b1011, ser_en=1.
  - req_ready=4'b0010 for one cycle.
  - Next 4 cycles: ser_valid=1, ser_dout=1,0,1,1, ser_id=1.
  - ser_start on cycle 1, ser_last on cycle 4, then IDLE.
- Full contention: all four requesters valid continuously. Required: grants in order 0,1,2,3,0,1; each frame occupies 5 cycles; never two ready bits high at once.
- Stall: ser_en=0 for 3 cycles after bit 1 of data 4'b1100. Required: ser_dout held at 1; frame totals 7 cycles; ser_last appears only on the 4th bit.
- Wrap and fairness: grant requester 3, then requesters 0 and 3 request together. Required: requester 0 wins (ptr=0), requester 3 is served next.
- Reset mid-frame: rst_n low during bit 2 of requester 2's frame, requester 2 keeps req_valid high. Required: ser_valid drops immediately; after release, requester 2 gets a fresh full frame with ser_start on its first bit.
